// File: rtl/mem_pkg.sv
// Shared types for the MMU-side request path: arbiter states, ownership, request payload
// and translation context. The MMU imports the same request and context structs.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] value;
    logic [3:0]  wstrb;
    logic        is_fetch;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] satp;
    logic        mxr;
    logic        mprv;
    logic [1:0]  mpp;
    logic        sum;
    logic [1:0]  priv;
  } xlate_ctx_t;

  // Fetches never write, so their value/strobe fields are forced to zero.
  function automatic mem_req_t make_req(input logic        is_fetch,
                                        input logic [31:0] addr,
                                        input logic [31:0] value,
                                        input logic [3:0]  wstrb);
    mem_req_t r;
    r.addr     = addr;
    r.value    = is_fetch ? 32'h0 : value;
    r.wstrb    = is_fetch ? 4'h0 : wstrb;
    r.is_fetch = is_fetch;
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data, CSR-context and MMU signals around the arbiter.
// slave = arbiter side, master = core/CSR/MMU side.
interface mem_arbiter_if;

  logic        if_req_valid_i;
  logic [31:0] if_req_addr_i;
  logic        flush_i;

  logic        d_req_valid_i;
  logic [31:0] d_req_addr_i;
  logic [31:0] d_req_value_i;
  logic [3:0]  d_req_wstrb_i;

  logic [31:0] satp_i;
  logic        mxr_i;
  logic        mprv_i;
  logic [1:0]  mpp_i;
  logic        sum_i;
  logic [1:0]  priv_i;

  logic        if_resp_valid_o;
  logic [31:0] if_resp_value_o;
  logic        if_resp_ex_valid_o;
  logic [31:0] if_resp_ex_code_o;

  logic        d_resp_valid_o;
  logic [31:0] d_resp_value_o;
  logic        d_resp_ex_valid_o;
  logic [31:0] d_resp_ex_code_o;

  logic        req_valid_o;
  logic [31:0] req_addr_o;
  logic [31:0] req_value_o;
  logic [3:0]  req_wstrb_o;
  logic        req_is_fetch_o;
  logic [31:0] req_satp_o;
  logic        req_mxr_o;
  logic        req_mprv_o;
  logic [1:0]  req_mpp_o;
  logic        req_sum_o;
  logic [1:0]  req_priv_o;

  logic        resp_valid_i;
  logic [31:0] resp_value_i;
  logic        resp_ex_valid_i;
  logic [31:0] resp_ex_code_i;

  modport slave (
    input  if_req_valid_i, if_req_addr_i, flush_i,
    input  d_req_valid_i, d_req_addr_i, d_req_value_i, d_req_wstrb_i,
    input  satp_i, mxr_i, mprv_i, mpp_i, sum_i, priv_i,
    output if_resp_valid_o, if_resp_value_o, if_resp_ex_valid_o, if_resp_ex_code_o,
    output d_resp_valid_o, d_resp_value_o, d_resp_ex_valid_o, d_resp_ex_code_o,
    output req_valid_o, req_addr_o, req_value_o, req_wstrb_o, req_is_fetch_o,
    output req_satp_o, req_mxr_o, req_mprv_o, req_mpp_o, req_sum_o, req_priv_o,
    input  resp_valid_i, resp_value_i, resp_ex_valid_i, resp_ex_code_i
  );

  modport master (
    output if_req_valid_i, if_req_addr_i, flush_i,
    output d_req_valid_i, d_req_addr_i, d_req_value_i, d_req_wstrb_i,
    output satp_i, mxr_i, mprv_i, mpp_i, sum_i, priv_i,
    input  if_resp_valid_o, if_resp_value_o, if_resp_ex_valid_o, if_resp_ex_code_o,
    input  d_resp_valid_o, d_resp_value_o, d_resp_ex_valid_o, d_resp_ex_code_o,
    input  req_valid_o, req_addr_o, req_value_o, req_wstrb_o, req_is_fetch_o,
    input  req_satp_o, req_mxr_o, req_mprv_o, req_mpp_o, req_sum_o, req_priv_o,
    output resp_valid_i, resp_value_i, resp_ex_valid_i, resp_ex_code_i
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant, combinational from requests; the last-grant register only
// advances when enabled and something is granted. Resets to data so fetch wins the first tie.
module rr_arb2
  import mem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_fetch,
  input  logic req_data,
  output logic gnt_fetch,
  output logic gnt_data,
  output logic gnt_any
);

  owner_e last_grant_q;

  always_comb begin
    gnt_fetch = req_fetch & (~req_data | (last_grant_q == OWNER_DATA));
    gnt_data  = req_data  & (~req_fetch | (last_grant_q == OWNER_FETCH));
    gnt_any   = req_fetch | req_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= OWNER_DATA;
    end else if (en && gnt_any) begin
      last_grant_q <= gnt_fetch ? OWNER_FETCH : OWNER_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Merges fetch and load/store onto the single MMU port with one access outstanding; payload and
// context are frozen at grant, responses route back combinationally, flushed fetches are drained.
module mem_arbiter
  import mem_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  mem_arbiter_if.slave  bus
);

  arb_state_e state_q;
  owner_e     owner_q;
  mem_req_t   req_q;
  xlate_ctx_t ctx_q;

  logic resp_ev;
  logic cand_fetch;
  logic cand_data;
  logic arb_en;
  logic gnt_fetch;
  logic gnt_data;
  logic gnt_any;
  logic owned_fetch;
  logic owned_data;

  assign resp_ev    = bus.resp_valid_i | bus.resp_ex_valid_i;
  assign cand_fetch = bus.if_req_valid_i & ~bus.flush_i;
  assign cand_data  = bus.d_req_valid_i;
  assign arb_en     = (state_q == IDLE);

  rr_arb2 u_rr_arb2 (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .en        (arb_en),
    .req_fetch (cand_fetch),
    .req_data  (cand_data),
    .gnt_fetch (gnt_fetch),
    .gnt_data  (gnt_data),
    .gnt_any   (gnt_any)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= OWNER_FETCH;
      req_q   <= '0;
      ctx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            owner_q <= gnt_data ? OWNER_DATA : OWNER_FETCH;
            req_q   <= make_req(gnt_fetch,
                                gnt_fetch ? bus.if_req_addr_i : bus.d_req_addr_i,
                                bus.d_req_value_i,
                                bus.d_req_wstrb_i);
            ctx_q   <= '{satp: bus.satp_i, mxr: bus.mxr_i, mprv: bus.mprv_i,
                         mpp: bus.mpp_i, sum: bus.sum_i, priv: bus.priv_i};
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (resp_ev) begin
            state_q <= IDLE;
          end else if (bus.flush_i && owner_q == OWNER_FETCH) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // The MMU cannot abort, so wait out its response and discard it.
          if (resp_ev) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A flush coinciding with the fetch response suppresses that response.
  assign owned_fetch = (state_q == BUSY) && (owner_q == OWNER_FETCH) && !bus.flush_i;
  assign owned_data  = (state_q == BUSY) && (owner_q == OWNER_DATA);

  assign bus.if_resp_valid_o    = bus.resp_valid_i & owned_fetch;
  assign bus.if_resp_ex_valid_o = bus.resp_ex_valid_i & owned_fetch;
  assign bus.if_resp_value_o    = owned_fetch ? bus.resp_value_i : 32'h0;
  assign bus.if_resp_ex_code_o  = owned_fetch ? bus.resp_ex_code_i : 32'h0;

  assign bus.d_resp_valid_o     = bus.resp_valid_i & owned_data;
  assign bus.d_resp_ex_valid_o  = bus.resp_ex_valid_i & owned_data;
  assign bus.d_resp_value_o     = owned_data ? bus.resp_value_i : 32'h0;
  assign bus.d_resp_ex_code_o   = owned_data ? bus.resp_ex_code_i : 32'h0;

  assign bus.req_valid_o    = (state_q != IDLE) & ~resp_ev;
  assign bus.req_addr_o     = req_q.addr;
  assign bus.req_value_o    = req_q.value;
  assign bus.req_wstrb_o    = req_q.wstrb;
  assign bus.req_is_fetch_o = req_q.is_fetch;

  assign bus.req_satp_o = ctx_q.satp;
  assign bus.req_mxr_o  = ctx_q.mxr;
  assign bus.req_mprv_o = ctx_q.mprv;
  assign bus.req_mpp_o  = ctx_q.mpp;
  assign bus.req_sum_o  = ctx_q.sum;
  assign bus.req_priv_o = ctx_q.priv;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; inputs change 1ns after the rising edge, outputs are sampled
// on the falling edge of the same cycle.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus.if_req_valid_i  = 1'b0;
    bus.if_req_addr_i   = 32'h0;
    bus.flush_i         = 1'b0;
    bus.d_req_valid_i   = 1'b0;
    bus.d_req_addr_i    = 32'h0;
    bus.d_req_value_i   = 32'h0;
    bus.d_req_wstrb_i   = 4'h0;
    bus.satp_i          = 32'h0;
    bus.mxr_i           = 1'b0;
    bus.mprv_i          = 1'b0;
    bus.mpp_i           = 2'b00;
    bus.sum_i           = 1'b0;
    bus.priv_i          = 2'b00;
    bus.resp_valid_i    = 1'b0;
    bus.resp_value_i    = 32'h0;
    bus.resp_ex_valid_i = 1'b0;
    bus.resp_ex_code_i  = 32'h0;
  endtask

  // Advance to the next cycle; inputs set after this apply to that cycle.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nxt();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    clear_inputs();
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_valid_o !== 1'b0) begin
      failures++; $display("FAIL rst_req_valid got=%0h exp=0", bus.req_valid_o);
    end
    checks++;
    if (bus.req_addr_o !== 32'h0 || bus.req_satp_o !== 32'h0 || bus.req_is_fetch_o !== 1'b0) begin
      failures++; $display("FAIL rst_payload got addr=%0h satp=%0h fetch=%0h exp=0",
                           bus.req_addr_o, bus.req_satp_o, bus.req_is_fetch_o);
    end
    checks++;
    if (bus.if_resp_valid_o !== 1'b0 || bus.d_resp_valid_o !== 1'b0) begin
      failures++; $display("FAIL rst_resp got if=%0h d=%0h exp=0", bus.if_resp_valid_o, bus.d_resp_valid_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    nxt();
  endtask

  task automatic test_single_fetch();
    bus.if_req_valid_i = 1'b1;
    bus.if_req_addr_i  = 32'h8000_0000;
    @(negedge clk);
    checks++;
    if (bus.req_valid_o !== 1'b0) begin
      failures++; $display("FAIL sf_c0_req_valid got=%0h exp=0", bus.req_valid_o);
    end
    nxt();
    @(negedge clk);
    checks++;
    if (bus.req_valid_o !== 1'b1 || bus.req_is_fetch_o !== 1'b1) begin
      failures++; $display("FAIL sf_c1_req got valid=%0h fetch=%0h exp=1/1", bus.req_valid_o, bus.req_is_fetch_o);
    end
    checks++;
    if (bus.req_addr_o !== 32'h8000_0000 || bus.req_wstrb_o !== 4'h0 || bus.req_value_o !== 32'h0) begin
      failures++; $display("FAIL sf_c1_payload got addr=%0h wstrb=%0h value=%0h exp=80000000/0/0",
                           bus.req_addr_o, bus.req_wstrb_o, bus.req_value_o);
    end
    nxt();
    @(negedge clk);
    checks++;
    if (bus.req_valid_o !== 1'b1) begin
      failures++; $display("FAIL sf_c2_req_valid got=%0h exp=1", bus.req_valid_o);
    end
    nxt();
    bus.resp_valid_i = 1'b1;
    bus.resp_value_i = 32'h0000_0013;
    @(negedge clk);
    checks++;
    if (bus.if_resp_valid_o !== 1'b1 || bus.if_resp_value_o !== 32'h13) begin
      failures++; $display("FAIL sf_c3_if_resp got valid=%0h value=%0h exp=1/13",
                           bus.if_resp_valid_o, bus.if_resp_value_o);
    end
    checks++;
    if (bus.d_resp_valid_o !== 1'b0 || bus.req_valid_o !== 1'b0) begin
      failures++; $display("FAIL sf_c3_other got d_valid=%0h req_valid=%0h exp=0/0",
                           bus.d_resp_valid_o, bus.req_valid_o);
    end
    nxt();
    bus.resp_valid_i   = 1'b0;
    bus.resp_value_i   = 32'h0;
    bus.if_req_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_valid_o !== 1'b0) begin
      failures++; $display("FAIL sf_c4_idle got=%0h exp=0", bus.req_valid_o);
    end
    nxt();
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.if_req_valid_i = 1'b1;
    bus.if_req_addr_i  = 32'h8000_0004;
    bus.d_req_valid_i  = 1'b1;
    bus.d_req_addr_i   = 32'h8000_1000;
    bus.d_req_value_i  = 32'hDEAD_BEEF;
    bus.d_req_wstrb_i  = 4'hF;
    nxt();
    @(negedge clk);
    checks++;
    if (bus.req_valid_o !== 1'b1 || bus.req_is_fetch_o !== 1'b1 || bus.req_addr_o !== 32'h8000_0004) begin
      failures++; $display("FAIL rr_tie1 got valid=%0h fetch=%0h addr=%0h exp=1/1/80000004",
                           bus.req_valid_o, bus.req_is_fetch_o, bus.req_addr_o);
    end
    nxt();
    bus.resp_valid_i = 1'b1;
    bus.resp_value_i = 32'h11;
    @(negedge clk);
    checks++;
    if (bus.if_resp_valid_o !== 1'b1 || bus.d_resp_valid_o !== 1'b0) begin
      failures++; $display("FAIL rr_resp1 got if=%0h d=%0h exp=1/0", bus.if_resp_valid_o, bus.d_resp_valid_o);
    end
    nxt();
    bus.resp_valid_i = 1'b0;
    bus.resp_value_i = 32'h0;
    nxt();
    @(negedge clk);
    checks++;
    if (bus.req_valid_o !== 1'b1 || bus.req_is_fetch_o !== 1'b0 || bus.req_addr_o !== 32'h8000_1000) begin
      failures++; $display("FAIL rr_tie2 got valid=%0h fetch=%0h addr=%0h exp=1/0/80001000",
                           bus.req_valid_o, bus.req_is_fetch_o, bus.req_addr_o);
    end
    checks++;
    if (bus.req_wstrb_o !== 4'hF || bus.req_value_o !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL rr_store_payload got wstrb=%0h value=%0h exp=f/deadbeef",
                           bus.req_wstrb_o, bus.req_value_o);
    end
    nxt();
    bus.resp_valid_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.d_resp_valid_o !== 1'b1 || bus.if_resp_valid_o !== 1'b0) begin
      failures++; $display("FAIL rr_resp2 got d=%0h if=%0h exp=1/0", bus.d_resp_valid_o, bus.if_resp_valid_o);
    end
    nxt();
    bus.resp_valid_i = 1'b0;
    nxt();
    bus.d_req_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_valid_o !== 1'b1 || bus.req_is_fetch_o !== 1'b1) begin
      failures++; $display("FAIL rr_tie3 got valid=%0h fetch=%0h exp=1/1", bus.req_valid_o, bus.req_is_fetch_o);
    end
    nxt();
    bus.resp_valid_i = 1'b1;
    nxt();
    bus.resp_valid_i   = 1'b0;
    bus.if_req_valid_i = 1'b0;
    nxt();
  endtask

  task automatic test_flush();
    do_reset();
    bus.if_req_valid_i = 1'b1;
    bus.if_req_addr_i  = 32'h8000_0100;
    nxt();
    @(negedge clk);
    checks++;
    if (bus.req_valid_o !== 1'b1) begin
      failures++; $display("FAIL fl_c1_req_valid got=%0h exp=1", bus.req_valid_o);
    end
    nxt();
    bus.flush_i       = 1'b1;
    bus.d_req_valid_i = 1'b1;
    bus.d_req_addr_i  = 32'h0000_0200;
    @(negedge clk);
    checks++;
    if (bus.req_valid_o !== 1'b1 || bus.if_resp_valid_o !== 1'b0) begin
      failures++; $display("FAIL fl_c2 got req_valid=%0h if_resp=%0h exp=1/0", bus.req_valid_o, bus.if_resp_valid_o);
    end
    nxt();
    bus.flush_i        = 1'b0;
    bus.if_req_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_valid_o !== 1'b1 || bus.req_is_fetch_o !== 1'b1) begin
      failures++; $display("FAIL fl_c3_drain got valid=%0h fetch=%0h exp=1/1", bus.req_valid_o, bus.req_is_fetch_o);
    end
    nxt();
    bus.resp_valid_i = 1'b1;
    bus.resp_value_i = 32'h77;
    @(negedge clk);
    checks++;
    if (bus.if_resp_valid_o !== 1'b0 || bus.d_resp_valid_o !== 1'b0 || bus.req_valid_o !== 1'b0) begin
      failures++; $display("FAIL fl_c4_silent got if=%0h d=%0h req_valid=%0h exp=0/0/0",
                           bus.if_resp_valid_o, bus.d_resp_valid_o, bus.req_valid_o);
    end
    nxt();
    bus.resp_valid_i = 1'b0;
    bus.resp_value_i = 32'h0;
    @(negedge clk);
    checks++;
    if (bus.req_valid_o !== 1'b0) begin
      failures++; $display("FAIL fl_c5_idle got=%0h exp=0", bus.req_valid_o);
    end
    nxt();
    @(negedge clk);
    checks++;
    if (bus.req_valid_o !== 1'b1 || bus.req_is_fetch_o !== 1'b0 || bus.req_addr_o !== 32'h200) begin
      failures++; $display("FAIL fl_c6_data_grant got valid=%0h fetch=%0h addr=%0h exp=1/0/200",
                           bus.req_valid_o, bus.req_is_fetch_o, bus.req_addr_o);
    end
    nxt();
    bus.resp_valid_i = 1'b1;
    bus.resp_value_i = 32'hA5;
    @(negedge clk);
    checks++;
    if (bus.d_resp_valid_o !== 1'b1 || bus.d_resp_value_o !== 32'hA5) begin
      failures++; $display("FAIL fl_data_resp got valid=%0h value=%0h exp=1/a5", bus.d_resp_valid_o, bus.d_resp_value_o);
    end
    nxt();
    bus.resp_valid_i  = 1'b0;
    bus.resp_value_i  = 32'h0;
    bus.d_req_valid_i = 1'b0;
    nxt();
  endtask

  task automatic test_flush_with_resp();
    bus.if_req_valid_i = 1'b1;
    bus.if_req_addr_i  = 32'h8000_0200;
    nxt();
    nxt();
    bus.flush_i      = 1'b1;
    bus.resp_valid_i = 1'b1;
    bus.resp_value_i = 32'h99;
    @(negedge clk);
    checks++;
    if (bus.if_resp_valid_o !== 1'b0 || bus.if_resp_value_o !== 32'h0 || bus.req_valid_o !== 1'b0) begin
      failures++; $display("FAIL fr_suppress got if=%0h value=%0h req_valid=%0h exp=0/0/0",
                           bus.if_resp_valid_o, bus.if_resp_value_o, bus.req_valid_o);
    end
    nxt();
    bus.flush_i        = 1'b0;
    bus.resp_valid_i   = 1'b0;
    bus.resp_value_i   = 32'h0;
    bus.if_req_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_valid_o !== 1'b0) begin
      failures++; $display("FAIL fr_idle_not_drain got=%0h exp=0", bus.req_valid_o);
    end
    nxt();
  endtask

  task automatic test_exception();
    bus.d_req_valid_i = 1'b1;
    bus.d_req_addr_i  = 32'h8000_2000;
    bus.d_req_wstrb_i = 4'h0;
    bus.d_req_value_i = 32'h0;
    nxt();
    @(negedge clk);
    checks++;
    if (bus.req_valid_o !== 1'b1 || bus.req_is_fetch_o !== 1'b0 || bus.req_wstrb_o !== 4'h0) begin
      failures++; $display("FAIL ex_load_req got valid=%0h fetch=%0h wstrb=%0h exp=1/0/0",
                           bus.req_valid_o, bus.req_is_fetch_o, bus.req_wstrb_o);
    end
    nxt();
    bus.resp_ex_valid_i = 1'b1;
    bus.resp_ex_code_i  = 32'd13;
    bus.resp_value_i    = 32'h55;
    @(negedge clk);
    checks++;
    if (bus.d_resp_ex_valid_o !== 1'b1 || bus.d_resp_ex_code_o !== 32'd13 || bus.d_resp_valid_o !== 1'b0) begin
      failures++; $display("FAIL ex_data_route got ex=%0h code=%0d valid=%0h exp=1/13/0",
                           bus.d_resp_ex_valid_o, bus.d_resp_ex_code_o, bus.d_resp_valid_o);
    end
    checks++;
    if (bus.if_resp_valid_o !== 1'b0 || bus.if_resp_ex_valid_o !== 1'b0 ||
        bus.if_resp_ex_code_o !== 32'h0 || bus.if_resp_value_o !== 32'h0) begin
      failures++; $display("FAIL ex_fetch_quiet got v=%0h ex=%0h code=%0h val=%0h exp=0/0/0/0",
                           bus.if_resp_valid_o, bus.if_resp_ex_valid_o, bus.if_resp_ex_code_o, bus.if_resp_value_o);
    end
    checks++;
    if (bus.req_valid_o !== 1'b0) begin
      failures++; $display("FAIL ex_req_drop got=%0h exp=0", bus.req_valid_o);
    end
    nxt();
    bus.resp_ex_valid_i = 1'b0;
    bus.resp_ex_code_i  = 32'h0;
    bus.resp_value_i    = 32'h0;
    bus.d_req_valid_i   = 1'b0;
    nxt();
  endtask

  task automatic test_context();
    bus.satp_i = 32'h8000_0010;
    bus.priv_i = 2'b01;
    bus.mxr_i  = 1'b1;
    bus.sum_i  = 1'b1;
    bus.mpp_i  = 2'b11;
    bus.mprv_i = 1'b1;
    bus.if_req_valid_i = 1'b1;
    bus.if_req_addr_i  = 32'h8000_0300;
    nxt();
    bus.satp_i = 32'h0;
    bus.priv_i = 2'b11;
    bus.mxr_i  = 1'b0;
    bus.mpp_i  = 2'b00;
    @(negedge clk);
    checks++;
    if (bus.req_satp_o !== 32'h8000_0010 || bus.req_priv_o !== 2'b01 || bus.req_mxr_o !== 1'b1) begin
      failures++; $display("FAIL ctx_c1 got satp=%0h priv=%0h mxr=%0h exp=80000010/1/1",
                           bus.req_satp_o, bus.req_priv_o, bus.req_mxr_o);
    end
    nxt();
    @(negedge clk);
    checks++;
    if (bus.req_satp_o !== 32'h8000_0010 || bus.req_mpp_o !== 2'b11 ||
        bus.req_sum_o !== 1'b1 || bus.req_mprv_o !== 1'b1) begin
      failures++; $display("FAIL ctx_c2 got satp=%0h mpp=%0h sum=%0h mprv=%0h exp=80000010/3/1/1",
                           bus.req_satp_o, bus.req_mpp_o, bus.req_sum_o, bus.req_mprv_o);
    end
    nxt();
    bus.resp_valid_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_satp_o !== 32'h8000_0010 || bus.if_resp_valid_o !== 1'b1) begin
      failures++; $display("FAIL ctx_resp got satp=%0h if_resp=%0h exp=80000010/1", bus.req_satp_o, bus.if_resp_valid_o);
    end
    nxt();
    clear_inputs();
    nxt();
  endtask

  task automatic test_reset_mid();
    bus.d_req_valid_i = 1'b1;
    bus.d_req_addr_i  = 32'h0000_3000;
    bus.d_req_value_i = 32'h0000_1234;
    bus.d_req_wstrb_i = 4'h3;
    nxt();
    @(negedge clk);
    checks++;
    if (bus.req_valid_o !== 1'b1 || bus.req_value_o !== 32'h1234 || bus.req_wstrb_o !== 4'h3) begin
      failures++; $display("FAIL rm_busy got valid=%0h value=%0h wstrb=%0h exp=1/1234/3",
                           bus.req_valid_o, bus.req_value_o, bus.req_wstrb_o);
    end
    #1;
    rst_n = 1'b0;
    bus.d_req_valid_i = 1'b0;
    #1;
    checks++;
    if (bus.req_valid_o !== 1'b0 || bus.req_addr_o !== 32'h0 ||
        bus.req_value_o !== 32'h0 || bus.req_wstrb_o !== 4'h0) begin
      failures++; $display("FAIL rm_async got valid=%0h addr=%0h value=%0h wstrb=%0h exp=0/0/0/0",
                           bus.req_valid_o, bus.req_addr_o, bus.req_value_o, bus.req_wstrb_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    nxt();
    bus.resp_valid_i = 1'b1;
    bus.resp_value_i = 32'hBAD;
    @(negedge clk);
    checks++;
    if (bus.d_resp_valid_o !== 1'b0 || bus.if_resp_valid_o !== 1'b0 || bus.d_resp_value_o !== 32'h0) begin
      failures++; $display("FAIL rm_late_resp got d=%0h if=%0h dval=%0h exp=0/0/0",
                           bus.d_resp_valid_o, bus.if_resp_valid_o, bus.d_resp_value_o);
    end
    nxt();
    clear_inputs();
    nxt();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_flush();
    test_flush_with_resp();
    test_exception();
    test_context();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
